// File: rtl/cycle_perf_reader_if.sv
// cycle_perf_reader_if: 32-bit load/store register bus between CPU and peripheral
interface cycle_perf_reader_if;
  logic [4:0]  addr;
  logic        re;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  modport master(output addr, re, we, wdata, input rdata, rvalid);
  modport slave(input addr, re, we, wdata, output rdata, rvalid);
endinterface

// File: rtl/cycle_perf_reader.sv
// cycle_perf_reader: run/halt-gated cycle and retired-instruction counters with shadowed 2-word reads
module cycle_perf_reader #(
  parameter int CNT_W = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                prog_start,
  input  logic                halt,
  input  logic                instr_retire,
  cycle_perf_reader_if.slave  bus,
  output logic                running,
  output logic                cnt_ovf
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cycle, instret, cyc_n, ret_n;
  logic             cyc_c, ret_c;
  logic [31:0]      shadow, rd_mux;
  logic             stop_on_halt;
  logic [2:0]       idx;
  logic             rd, ctrl_wr, clr, run;
  assign idx     = bus.addr[4:2];
  assign rd      = bus.re & ~bus.we;
  assign ctrl_wr = bus.we && idx == 3'd0;
  assign clr     = ctrl_wr & bus.wdata[1];
  assign run     = state == RUN;
  assign running = run;
  assign {cyc_c, cyc_n} = {1'b0, cycle} + {{CNT_W{1'b0}}, 1'b1};
  assign {ret_c, ret_n} = {1'b0, instret} + {{CNT_W{1'b0}}, 1'b1};
  // next state: clear wins, then start/enable, then disable, then halt
  always_comb begin
    state_nx = clr ? IDLE
             : (state == IDLE && (prog_start || (ctrl_wr && bus.wdata[0]))) ? RUN
             : (run && ctrl_wr && !bus.wdata[0]) ? IDLE
             : (run && halt && stop_on_halt) ? HALT
             : state;
  end
  // read-data mux over the register map; HI words return the shared shadow
  always_comb begin
    rd_mux = '0;
    case (idx)
      3'd0: rd_mux = {29'b0, stop_on_halt, 1'b0, run};
      3'd1: rd_mux = {29'b0, cnt_ovf, state};
      3'd2: rd_mux = cycle[31:0];
      3'd3: rd_mux = shadow;
      3'd4: rd_mux = instret[31:0];
      3'd5: rd_mux = shadow;
      default: rd_mux = '0;
    endcase
  end
  // state register, counters, snapshot and control bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cycle        <= '0;
      instret      <= '0;
      shadow       <= '0;
      stop_on_halt <= 1'b1;
      cnt_ovf      <= 1'b0;
    end else begin
      state        <= state_nx;
      cycle        <= clr ? '0 : run ? cyc_n : cycle;
      instret      <= clr ? '0 : (run && instr_retire) ? ret_n : instret;
      cnt_ovf      <= clr ? 1'b0 : cnt_ovf | (run & cyc_c) | (run & instr_retire & ret_c);
      stop_on_halt <= ctrl_wr ? bus.wdata[2] : stop_on_halt;
      shadow       <= clr ? '0
                    : (rd && idx == 3'd2) ? 32'(cycle[CNT_W-1:32])
                    : (rd && idx == 3'd4) ? 32'(instret[CNT_W-1:32])
                    : shadow;
    end
  end
  // registered read response; a read colliding with a write is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      bus.rdata  <= rd ? rd_mux : bus.rdata;
      bus.rvalid <= rd;
    end
  end
endmodule
